led_walker_master: RTL and testbench
====================================

# led_walker_master

Wishbone pipelined bus master that sits directly upstream of the LED walker peripheral and turns a stream of walk commands into single-beat bus transactions. Commands arrive on a valid/ready port, are buffered in a small FIFO, and are issued one at a time, honouring the slave's stall and ack. A per-transaction timeout aborts a cycle when the slave never acknowledges. Completion and error are reported as single-cycle pulses.

## Interface

Parameters:
- NUM_LEDS, 8, number of LEDs on the slave; sets the address width AW = $clog2(NUM_LEDS).
- FIFO_DEPTH, 4, command FIFO entries; must be a power of two and at least 2.
- TIMEOUT, 64, maximum cycles with o_wb_cyc high before abort; must be at least NUM_LEDS+4.

Ports (one clock; reset is synchronous and active-high):
- i_clk, in, 1, clock.
- i_reset, in, 1, synchronous active-high reset.
- i_cmd_valid, in, 1, a command is presented.
- o_cmd_ready, out, 1, the FIFO can accept a command; equals !full.
- i_cmd_addr, in, AW, start LED index.
- i_cmd_we, in, 1, 1 = write (start walk), 0 = read.
- o_wb_cyc, out, 1, bus cycle active.
- o_wb_stb, out, 1, request strobe.
- o_wb_we, out, 1, write enable of the current request.
- o_wb_addr, out, AW, address of the current request.
- o_wb_data, out, 1, write data; driven 1 for writes, 0 for reads.
- i_wb_stall, in, 1, slave not accepting the request.
- i_wb_ack, in, 1, slave completes the request.
- o_busy, out, 1, high whenever state != IDLE or the FIFO is non-empty.
- o_done, out, 1, one-cycle pulse on each acked transaction.
- o_err, out, 1, one-cycle pulse on each timeout abort.

## Operation

- FIFO: the entry is {we, addr}. Push on i_cmd_valid && o_cmd_ready. Pop only in IDLE when non-empty. Push and pop in the same cycle are both honoured. There is no fall-through: a command pushed into an empty FIFO is popped on the following cycle.
- State machine, states IDLE, REQ, WAIT, cleared to IDLE on reset:
  - IDLE to REQ: FIFO non-empty. On that edge, pop, load o_wb_addr and o_wb_we, set o_wb_cyc=1, o_wb_stb=1, and clear the timeout counter.
  - In REQ:
    - i_wb_stall=0: the request is accepted at the edge. Drop o_wb_stb next cycle and go to WAIT.
    - i_wb_ack=1 in the same cycle as acceptance: go straight to IDLE, drop o_wb_cyc, pulse o_done.
  - WAIT to IDLE: i_wb_ack=1. Drop o_wb_cyc and pulse o_done.
  - REQ or WAIT to IDLE on timeout: the counter reaches TIMEOUT-1 with no ack. Drop o_wb_cyc and o_wb_stb and pulse o_err. The command is discarded, not retried.
- i_wb_ack while in IDLE is ignored. i_wb_ack while o_wb_stb is high and stall is high is treated as a protocol error and is also ignored.
- Timeout counter: $clog2(TIMEOUT) bits. It increments every cycle o_wb_cyc is high and saturates; it never wraps.
- o_wb_addr and o_wb_we are held stable for the whole cycle, from REQ until return to IDLE.

## Timing

- Reset values: o_wb_cyc=0, o_wb_stb=0, o_wb_we=0, o_wb_addr=0, o_wb_data=0, o_done=0, o_err=0, o_busy=0. o_cmd_ready=1 in the cycle after reset.
- Reset mid-transaction: o_wb_cyc and o_wb_stb drop at the reset edge, the FIFO is flushed, and no o_done or o_err pulse is produced.
- Latency: command accepted at edge k, then o_wb_stb high from edge k+1.
- Back-to-back commands: at least one IDLE cycle with o_wb_cyc=0 between transactions.
- o_done and o_err are registered. Each is high exactly one cycle, in the same cycle o_wb_cyc first reads 0.
- FIFO full: o_cmd_ready=0 and i_cmd_valid is ignored. When a pop happens in that cycle, o_cmd_ready returns to 1 on the next cycle.
- Pointer wrap: read and write pointers are AW_F+1 bits (AW_F = $clog2(FIFO_DEPTH)) and wrap modulo 2*FIFO_DEPTH.
  - full when the MSBs differ and the rest are equal.
  - empty when the pointers are equal.

## Test plan

- Single write, slave with stall=0 and ack 3 cycles after acceptance. Command addr=2, we=1: o_wb_stb high exactly 1 cycle with addr=2, we=1, data=1; o_done pulses 4 cycles after stb; o_busy low afterwards.
- Stall handling: i_wb_stall=1 for 5 cycles. o_wb_stb and o_wb_addr are held for 6 cycles; then stb drops and WAIT is entered; ack arrives and o_done pulses once.
- FIFO fill: 6 commands pushed back-to-back with FIFO_DEPTH=4 and the slave holding stall. o_cmd_ready goes 0 after 5 accepted (4 in FIFO plus 1 popped). All accepted commands are issued in order with their addresses; the 6th is pushed once ready returns.
- Timeout: slave never acks, TIMEOUT=64. o_wb_cyc drops after exactly 64 cycles high; o_err pulses once; o_done stays 0; the next queued command is then issued.
- Reset mid-WAIT with 2 commands queued: the cycle after reset, o_wb_cyc=0, the FIFO is empty, o_busy=0, and no pulses appear.
- Against the LED walker with NUM_LEDS=8: write addr=0 then a read. Each is acked before timeout, giving 2 o_done pulses and no o_err.

Source files
------------

// File: rtl/led_walker_master.sv
// Wishbone pipelined master for the LED walker: buffers walk commands in a small
// FIFO and issues them as single-beat bus cycles with a per-cycle timeout abort.
module led_walker_master #(
  parameter int NUM_LEDS   = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_cmd_valid,
  output logic                        o_cmd_ready,
  input  logic [$clog2(NUM_LEDS)-1:0] i_cmd_addr,
  input  logic                        i_cmd_we,
  output logic                        o_wb_cyc,
  output logic                        o_wb_stb,
  output logic                        o_wb_we,
  output logic [$clog2(NUM_LEDS)-1:0] o_wb_addr,
  output logic                        o_wb_data,
  input  logic                        i_wb_stall,
  input  logic                        i_wb_ack,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_err
);

  // state | meaning
  // IDLE  | no bus cycle; pops the next command when the FIFO is non-empty
  // REQ   | cyc and stb high, waiting for the slave to drop stall
  // WAIT  | request accepted, stb low, waiting for ack or timeout
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  localparam int AW   = $clog2(NUM_LEDS);
  localparam int AW_F = $clog2(FIFO_DEPTH);
  localparam int TW   = $clog2(TIMEOUT);

  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  localparam logic [AW_F:0] PTR_ONE  = (AW_F + 1)'(1);

  logic [AW:0]     fifo_mem [FIFO_DEPTH];
  logic [AW_F:0]   wr_ptr;
  logic [AW_F:0]   rd_ptr;
  logic [AW:0]     head;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic [1:0]      state;
  logic [TW-1:0]   tmo_cnt;
  logic            tmo_hit;
  logic            accepted;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full  = (wr_ptr[AW_F] != rd_ptr[AW_F]) &&
                 (wr_ptr[AW_F-1:0] == rd_ptr[AW_F-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign push  = i_cmd_valid && !full;
  assign pop   = (state == IDLE) && !empty;
  assign head  = fifo_mem[rd_ptr[AW_F-1:0]];

  assign o_cmd_ready = !full;
  assign o_busy      = (state != IDLE) || !empty;

  assign tmo_hit  = (tmo_cnt == TMO_LAST);
  assign accepted = o_wb_stb && !i_wb_stall;

  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_mem[wr_ptr[AW_F-1:0]] <= {i_cmd_we, i_cmd_addr};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= IDLE;
      o_wb_cyc  <= 1'b0;
      o_wb_stb  <= 1'b0;
      o_wb_we   <= 1'b0;
      o_wb_addr <= '0;
      o_wb_data <= 1'b0;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      // Saturate rather than wrap so a stuck cycle can never look fresh again.
      if (o_wb_cyc && (tmo_cnt != '1)) begin
        tmo_cnt <= tmo_cnt + TMO_ONE;
      end
      case (state)
        IDLE: begin
          if (!empty) begin
            state     <= REQ;
            o_wb_cyc  <= 1'b1;
            o_wb_stb  <= 1'b1;
            o_wb_we   <= head[AW];
            o_wb_data <= head[AW];
            o_wb_addr <= head[AW-1:0];
            tmo_cnt   <= '0;
          end
        end
        REQ: begin
          // An ack while stalled is a slave protocol error and is ignored.
          if (accepted && i_wb_ack) begin
            state    <= IDLE;
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            o_done   <= 1'b1;
          end else if (tmo_hit) begin
            state    <= IDLE;
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            o_err    <= 1'b1;
          end else if (accepted) begin
            state    <= WAIT;
            o_wb_stb <= 1'b0;
          end
        end
        WAIT: begin
          if (i_wb_ack) begin
            state    <= IDLE;
            o_wb_cyc <= 1'b0;
            o_done   <= 1'b1;
          end else if (tmo_hit) begin
            state    <= IDLE;
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            o_err    <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          o_wb_cyc <= 1'b0;
          o_wb_stb <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_walker_master.sv
// Scoreboard bench for led_walker_master: stimulus pushes the expected bus
// transaction per accepted command, a monitor pops and checks each one.
`timescale 1ns/1ps
module tb_led_walker_master;
  localparam int NUM_LEDS   = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 64;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_cmd_valid;
  logic       o_cmd_ready;
  logic [2:0] i_cmd_addr;
  logic       i_cmd_we;
  logic       o_wb_cyc;
  logic       o_wb_stb;
  logic       o_wb_we;
  logic [2:0] o_wb_addr;
  logic       o_wb_data;
  logic       i_wb_stall;
  logic       i_wb_ack;
  logic       o_busy;
  logic       o_done;
  logic       o_err;

  led_walker_master #(.NUM_LEDS(NUM_LEDS), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_addr(i_cmd_addr), .i_cmd_we(i_cmd_we),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
    .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [2:0] addr;
    logic       we;
    int         stb_len;
    int         cyc_len;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // slave behaviour knobs
  int stall_len = 0;
  int ack_dly   = 3;
  bit bad_ack   = 0;
  bit dead_en   = 0;
  int dead_addr = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Slave model: decides stall/ack on the falling edge for the next rising edge.
  int sc = 0;
  int wcnt = 0;
  bit dead_now = 0;
  initial begin
    i_wb_stall = 1'b0;
    i_wb_ack   = 1'b0;
    forever begin
      @(negedge i_clk);
      if (i_reset || !o_wb_cyc) begin
        i_wb_stall = 1'b0;
        i_wb_ack   = 1'b0;
        sc = 0;
      end else if (o_wb_stb) begin
        if (sc < stall_len) begin
          i_wb_stall = 1'b1;
          i_wb_ack   = bad_ack;
          sc++;
        end else begin
          i_wb_stall = 1'b0;
          dead_now   = dead_en && (o_wb_addr == 3'(dead_addr));
          wcnt       = ack_dly;
          i_wb_ack   = (ack_dly == 0) && !dead_now;
        end
      end else begin
        i_wb_stall = 1'b0;
        if (wcnt > 0) wcnt--;
        i_wb_ack = (wcnt == 0) && !dead_now;
      end
    end
  end

  // Monitor / scoreboard
  int   cycle = 0;
  int   rise = 0;
  int   stb_cnt = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  logic prev_cyc = 1'b0;
  logic prev_stb = 1'b0;
  logic have_cur = 1'b0;
  exp_t cur;
  initial begin
    forever begin
      @(posedge i_clk);
      #2;
      cycle++;
      if (i_reset) begin
        prev_cyc = 1'b0;
        prev_stb = 1'b0;
        have_cur = 1'b0;
        stb_cnt  = 0;
      end else begin
        if (o_wb_stb && !prev_stb) begin
          check("req_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            have_cur = 1'b1;
            rise = cycle;
            stb_cnt = 0;
            check("req_addr", int'(o_wb_addr), int'(cur.addr));
            check("req_we", int'(o_wb_we), int'(cur.we));
            check("req_data", int'(o_wb_data), int'(cur.we));
            check("req_cyc", int'(o_wb_cyc), 1);
          end
        end
        if (o_wb_stb) stb_cnt++;
        if (o_wb_cyc && have_cur) begin
          check("addr_hold", int'(o_wb_addr), int'(cur.addr));
          check("we_hold", int'(o_wb_we), int'(cur.we));
        end
        if (!o_wb_stb && prev_stb && have_cur)
          check("stb_len", stb_cnt, cur.stb_len);
        if (o_done || o_err) begin
          done_cnt += int'(o_done);
          err_cnt  += int'(o_err);
          check("pulse_expected", int'(have_cur), 1);
          if (have_cur) begin
            check("err_flag", int'(o_err), int'(cur.err));
            check("done_flag", int'(o_done), int'(!cur.err));
            check("cyc_len", cycle - rise, cur.cyc_len);
            check("cyc_low_at_pulse", int'(o_wb_cyc), 0);
            have_cur = 1'b0;
          end
        end
        if (!o_wb_cyc && prev_cyc)
          check("pulse_on_cyc_drop", int'(o_done | o_err), 1);
        prev_cyc = o_wb_cyc;
        prev_stb = o_wb_stb;
      end
    end
  end

  task automatic send(input logic [2:0] a, input logic w);
    exp_t e;
    bit ok = 0;
    bit dead;
    @(negedge i_clk);
    i_cmd_valid = 1'b1;
    i_cmd_addr  = a;
    i_cmd_we    = w;
    for (int n = 0; n < 500 && !ok; n++) begin
      if (o_cmd_ready) begin
        dead      = dead_en && (a == 3'(dead_addr));
        e.addr    = a;
        e.we      = w;
        e.err     = dead;
        e.stb_len = stall_len + 1;
        e.cyc_len = dead ? TIMEOUT : stall_len + 1 + ack_dly;
        @(posedge i_clk);
        exp_q.push_back(e);
        ok = 1;
        #1;
      end else begin
        @(negedge i_clk);
      end
    end
    i_cmd_valid = 1'b0;
    check("cmd_accepted", int'(ok), 1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((o_busy || o_wb_cyc || exp_q.size() != 0 || have_cur) && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    check("idle_reached", int'(n < budget), 1);
    repeat (2) @(negedge i_clk);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int e0;
    int seen;
    int n;
    i_reset     = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd_addr  = 3'd0;
    i_cmd_we    = 1'b0;
    repeat (3) @(negedge i_clk);
    check("rst_cyc", int'(o_wb_cyc), 0);
    check("rst_stb", int'(o_wb_stb), 0);
    check("rst_we", int'(o_wb_we), 0);
    check("rst_addr", int'(o_wb_addr), 0);
    check("rst_data", int'(o_wb_data), 0);
    check("rst_done", int'(o_done), 0);
    check("rst_err", int'(o_err), 0);
    check("rst_busy", int'(o_busy), 0);
    i_reset = 1'b0;
    @(negedge i_clk);
    check("rst_ready", int'(o_cmd_ready), 1);

    // single write, ack 3 cycles after acceptance
    stall_len = 0; ack_dly = 3;
    send(3'd2, 1'b1);
    @(posedge i_clk);
    #2;
    check("latency_stb", int'(o_wb_stb), 1);
    wait_idle(200);
    check("busy_after_write", int'(o_busy), 0);

    // stall for 5 cycles with spurious acks during the stall
    stall_len = 5; ack_dly = 2; bad_ack = 1;
    send(3'd5, 1'b0);
    wait_idle(200);
    bad_ack = 0;

    // FIFO fill behind a stalling slave
    stall_len = 3; ack_dly = 1;
    for (int i = 0; i < 5; i++) send(3'(i), i[0]);
    @(negedge i_clk);
    check("ready_full", int'(o_cmd_ready), 0);
    send(3'd7, 1'b1);
    wait_idle(500);

    // timeout on addr 5, then a normal command behind it
    stall_len = 0; ack_dly = 2; dead_en = 1; dead_addr = 5;
    d0 = done_cnt; e0 = err_cnt;
    send(3'd5, 1'b1);
    send(3'd6, 1'b0);
    wait_idle(300);
    check("timeout_err_count", err_cnt - e0, 1);
    check("timeout_done_count", done_cnt - d0, 1);
    dead_en = 0;

    // reset while in WAIT with two commands queued
    stall_len = 0; ack_dly = 40;
    send(3'd1, 1'b1);
    send(3'd2, 1'b0);
    send(3'd3, 1'b1);
    n = 0;
    while (!(o_wb_cyc && !o_wb_stb) && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    check("reached_wait", int'(n < 50), 1);
    @(negedge i_clk);
    exp_q.delete();
    i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    check("mid_rst_cyc", int'(o_wb_cyc), 0);
    check("mid_rst_stb", int'(o_wb_stb), 0);
    check("mid_rst_busy", int'(o_busy), 0);
    check("mid_rst_ready", int'(o_cmd_ready), 1);
    check("mid_rst_done", int'(o_done), 0);
    check("mid_rst_err", int'(o_err), 0);
    seen = 0;
    repeat (50) begin
      @(negedge i_clk);
      if (o_done || o_err || o_wb_cyc) seen++;
    end
    check("quiet_after_reset", seen, 0);

    // write addr 0 then read addr 0, both acked
    d0 = done_cnt; e0 = err_cnt;
    stall_len = 1; ack_dly = 0;
    send(3'd0, 1'b1);
    wait_idle(200);
    stall_len = 0; ack_dly = 2;
    send(3'd0, 1'b0);
    wait_idle(200);
    check("walker_done_count", done_cnt - d0, 2);
    check("walker_err_count", err_cnt - e0, 0);

    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
